// File: rtl/k_and_s_pkg.sv
// Shared opcode constants, decoded-instruction enum, ALU op enum and IR field positions.
// Imported by ks_alu and ks_data_path_param.
package k_and_s_pkg;

    localparam int IR_W    = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int C_LSB   = 8;
    localparam int A_LSB   = 4;
    localparam int B_LSB   = 0;

    localparam logic [3:0] OPC_NOP    = 4'h0;
    localparam logic [3:0] OPC_LOAD   = 4'h1;
    localparam logic [3:0] OPC_STORE  = 4'h2;
    localparam logic [3:0] OPC_MOVE   = 4'h3;
    localparam logic [3:0] OPC_ADD    = 4'h4;
    localparam logic [3:0] OPC_SUB    = 4'h5;
    localparam logic [3:0] OPC_AND    = 4'h6;
    localparam logic [3:0] OPC_OR     = 4'h7;
    localparam logic [3:0] OPC_BRANCH = 4'h8;
    localparam logic [3:0] OPC_BZERO  = 4'h9;
    localparam logic [3:0] OPC_BNEG   = 4'hA;
    localparam logic [3:0] OPC_HALT   = 4'hF;

    typedef enum logic [3:0] {
        I_NOP    = 4'h0,
        I_LOAD   = 4'h1,
        I_STORE  = 4'h2,
        I_MOVE   = 4'h3,
        I_ADD    = 4'h4,
        I_SUB    = 4'h5,
        I_AND    = 4'h6,
        I_OR     = 4'h7,
        I_BRANCH = 4'h8,
        I_BZERO  = 4'h9,
        I_BNEG   = 4'hA,
        I_HALT   = 4'hF
    } decoded_instruction_type;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic unsigned_overflow;
        logic signed_overflow;
    } flags_t;

    function automatic decoded_instruction_type decode_opcode(input logic [3:0] opc);
        case (opc)
            OPC_LOAD:   return I_LOAD;
            OPC_STORE:  return I_STORE;
            OPC_MOVE:   return I_MOVE;
            OPC_ADD:    return I_ADD;
            OPC_SUB:    return I_SUB;
            OPC_AND:    return I_AND;
            OPC_OR:     return I_OR;
            OPC_BRANCH: return I_BRANCH;
            OPC_BZERO:  return I_BZERO;
            OPC_BNEG:   return I_BNEG;
            OPC_HALT:   return I_HALT;
            default:    return I_NOP;
        endcase
    endfunction

endpackage

// File: rtl/ks_alu.sv
// Combinational ALU (ADD/SUB/AND/OR) with zero/neg/carry-borrow/signed-overflow flags.
// Zero latency, no flow control; the caller registers the flags.
module ks_alu
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  alu_op_t           op_i,
    output logic [DATA_W-1:0] result_o,
    output flags_t            flags_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic            uov;
    logic            sov;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    // The extra top bit of the widened difference is the borrow (a < b).
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        result_o = '0;
        uov      = 1'b0;
        sov      = 1'b0;
        case (op_i)
            ALU_ADD: begin
                result_o = sum[DATA_W-1:0];
                uov      = sum[DATA_W];
                sov      = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                           (sum[DATA_W-1] != a_i[DATA_W-1]);
            end
            ALU_SUB: begin
                result_o = diff[DATA_W-1:0];
                uov      = diff[DATA_W];
                sov      = (a_i[DATA_W-1] != b_i[DATA_W-1]) &&
                           (diff[DATA_W-1] != a_i[DATA_W-1]);
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            default: result_o = '0;
        endcase
    end

    assign flags_o.zero              = (result_o == '0);
    assign flags_o.neg               = result_o[DATA_W-1];
    assign flags_o.unsigned_overflow = uov;
    assign flags_o.signed_overflow   = sov;

endmodule

// File: rtl/ks_data_path_param.sv
// K&S datapath: PC, 16-bit IR with decode, 2R/1W register file, ALU and flags register; all state
// updates on enables, reads are combinational. Define KS_R0_ZERO_EN to hard-wire R0 to zero.
module ks_data_path_param
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    write_reg_enable,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       data_out,
    input  logic [DATA_W-1:0]       data_in
);

    localparam int RW = $clog2(NREGS);

    logic [IR_W-1:0]   ir_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    flags_t            flags_q;
    flags_t            alu_flags;
    logic [DATA_W-1:0] rf_q [NREGS];

    logic [ADDR_W-1:0] addr_field;
    logic [RW-1:0]     c_addr;
    logic [RW-1:0]     a_addr;
    logic [RW-1:0]     b_addr;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] wr_dat_d;
    logic              wr_en;
    logic              unused_ir_bits;

    assign decoded_instruction = decode_opcode(ir_q[OPC_MSB:OPC_LSB]);
    assign addr_field          = ir_q[ADDR_W-1:0];
    assign c_addr              = ir_q[C_LSB +: RW];
    assign unused_ir_bits      = ^ir_q;

    // LOAD/STORE read the register named by the C field; MOVE copies port A onto port B.
    always_comb begin
        a_addr = ir_q[A_LSB +: RW];
        b_addr = ir_q[B_LSB +: RW];
        if (decoded_instruction == I_LOAD || decoded_instruction == I_STORE) begin
            a_addr = ir_q[C_LSB +: RW];
        end
        if (decoded_instruction == I_MOVE) begin
            b_addr = a_addr;
        end
    end

    always_comb begin
        rd_a = rf_q[a_addr];
        rd_b = rf_q[b_addr];
`ifdef KS_R0_ZERO_EN
        if (a_addr == '0) rd_a = '0;
        if (b_addr == '0) rd_b = '0;
`endif
    end

`ifdef KS_R0_ZERO_EN
    assign wr_en = write_reg_enable && (c_addr != '0);
`else
    assign wr_en = write_reg_enable;
`endif

    ks_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i      (rd_a),
        .b_i      (rd_b),
        .op_i     (alu_op_t'(operation)),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    assign wr_dat_d = c_sel ? data_in : alu_result;
    assign pc_d     = branch ? addr_field : pc_q + ADDR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
        end else begin
            if (pc_enable)        pc_q    <= pc_d;
            if (ir_enable)        ir_q    <= data_in[IR_W-1:0];
            if (flags_reg_enable) flags_q <= alu_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (wr_en) begin
            rf_q[c_addr] <= wr_dat_d;
        end
    end

    assign ram_addr          = addr_sel ? addr_field : pc_q;
    assign data_out          = rd_a;
    assign zero_op           = flags_q.zero;
    assign neg_op            = flags_q.neg;
    assign unsigned_overflow = flags_q.unsigned_overflow;
    assign signed_overflow   = flags_q.signed_overflow;

endmodule

// File: tb/tb_ks_data_path_param.sv
// Bench for ks_data_path_param (DATA_W=16, ADDR_W=5, NREGS=4): directed literal cases
// plus randomized traffic compared every cycle against an arithmetic reference model.
module tb_ks_data_path_param;
    import k_and_s_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic [1:0] operation;
    logic write_reg_enable, flags_reg_enable;
    decoded_instruction_type decoded_instruction;
    logic zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic [4:0]  ram_addr;
    logic [15:0] data_out;
    logic [15:0] data_in;

    int errors = 0;
    int checks = 0;

    ks_data_path_param dut (
        .clk                 (clk),
        .rst                 (rst),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .write_reg_enable    (write_reg_enable),
        .flags_reg_enable    (flags_reg_enable),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .ram_addr            (ram_addr),
        .data_out            (data_out),
        .data_in             (data_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state only, outputs derived from the instruction-set rules.
    logic [15:0] m_rf [4];
    logic [4:0]  m_pc;
    logic [15:0] m_ir;
    logic [3:0]  m_fl; // {zero, neg, unsigned_ovf, signed_ovf}

    function automatic int port_a();
        int opc;
        opc = int'(m_ir[15:12]);
        if (opc == 1 || opc == 2) return int'(m_ir[9:8]);
        return int'(m_ir[5:4]);
    endfunction

    function automatic int port_b();
        if (int'(m_ir[15:12]) == 3) return port_a();
        return int'(m_ir[1:0]);
    endfunction

    function automatic logic [15:0] reg_read(input int idx);
`ifdef KS_R0_ZERO_EN
        if (idx == 0) return 16'h0000;
`endif
        return m_rf[idx];
    endfunction

    function automatic decoded_instruction_type exp_decode(input int opc);
        case (opc)
            1:  return I_LOAD;
            2:  return I_STORE;
            3:  return I_MOVE;
            4:  return I_ADD;
            5:  return I_SUB;
            6:  return I_AND;
            7:  return I_OR;
            8:  return I_BRANCH;
            9:  return I_BZERO;
            10: return I_BNEG;
            15: return I_HALT;
            default: return I_NOP;
        endcase
    endfunction

    task automatic model_alu(input logic [15:0] a, input logic [15:0] b, input int op,
                             output logic [15:0] res, output logic [3:0] fl);
        int ua, ub, sa, sb, r, sr;
        logic u, s;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        u = 1'b0; s = 1'b0; r = 0;
        case (op)
            0: begin r = ua + ub; sr = sa + sb; u = (r > 65535); s = (sr > 32767) || (sr < -32768); end
            1: begin r = ua - ub; sr = sa - sb; u = (ua < ub);   s = (sr > 32767) || (sr < -32768); end
            2: r = ua & ub;
            default: r = ua | ub;
        endcase
        res = r[15:0];
        fl  = {res == 16'h0, res[15], u, s};
    endtask

    always @(posedge clk or posedge rst) begin
        logic [15:0] res;
        logic [3:0]  fl;
        int c;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_rf[i] = 16'h0;
            m_pc = 5'd0;
            m_ir = 16'h0;
            m_fl = 4'h0;
        end else begin
            model_alu(reg_read(port_a()), reg_read(port_b()), int'(operation), res, fl);
            c = int'(m_ir[9:8]);
            if (write_reg_enable) m_rf[c] = c_sel ? data_in : res;
            if (flags_reg_enable) m_fl = fl;
            if (pc_enable) m_pc = branch ? m_ir[4:0] : m_pc + 5'd1;
            if (ir_enable) m_ir = data_in;
        end
    end

    always @(negedge clk) begin
        check("ram_addr", ram_addr, addr_sel ? m_ir[4:0] : m_pc);
        check("data_out", data_out, reg_read(port_a()));
        check("flags", {zero_op, neg_op, unsigned_overflow, signed_overflow}, m_fl);
        check("decode", decoded_instruction, exp_decode(int'(m_ir[15:12])));
    end

    task automatic step(input logic br, input logic pe, input logic ie, input logic as,
                        input logic cs, input logic [1:0] op, input logic we, input logic fe,
                        input logic [15:0] din);
        branch = br; pc_enable = pe; ir_enable = ie; addr_sel = as; c_sel = cs;
        operation = op; write_reg_enable = we; flags_reg_enable = fe; data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic load_reg(input logic [1:0] r, input logic [15:0] val);
        step(0, 0, 1, 0, 0, 2'b00, 0, 0, 16'h1000 | (16'(r) << 8));
        step(0, 0, 0, 0, 1, 2'b00, 1, 0, val);
    endtask

    initial begin
        rst = 1'b0;
        branch = 0; pc_enable = 0; ir_enable = 0; addr_sel = 0; c_sel = 0;
        operation = 2'b00; write_reg_enable = 0; flags_reg_enable = 0; data_in = 16'h0;
        #1 rst = 1'b1;
        #2;
        check("reset_ram_addr", ram_addr, 5'd0);
        check("reset_data_out", data_out, 16'h0);
        check("reset_decode", decoded_instruction, I_NOP);
        @(posedge clk); #1 rst = 1'b0;

        // ADD 0x7FFF + 0x0001 into R3
        load_reg(2'd1, 16'h7FFF);
        load_reg(2'd2, 16'h0001);
        step(0, 0, 1, 0, 0, 2'b00, 0, 0, 16'h4312);
        step(0, 0, 0, 0, 0, 2'b00, 1, 1, 16'h0);
        check("add_flags", {zero_op, neg_op, unsigned_overflow, signed_overflow}, 4'b0101);
        step(0, 0, 1, 0, 0, 2'b00, 0, 0, 16'h2300);
        check("add_r3", data_out, 16'h8000);

        // SUB 5-5 then 3-5
        load_reg(2'd1, 16'h0005);
        load_reg(2'd2, 16'h0005);
        step(0, 0, 1, 0, 0, 2'b00, 0, 0, 16'h5312);
        step(0, 0, 0, 0, 0, 2'b01, 1, 1, 16'h0);
        check("sub_eq_flags", {zero_op, neg_op, unsigned_overflow, signed_overflow}, 4'b1000);
        load_reg(2'd1, 16'h0003);
        step(0, 0, 1, 0, 0, 2'b00, 0, 0, 16'h5312);
        step(0, 0, 0, 0, 0, 2'b01, 1, 1, 16'h0);
        check("sub_lt_flags", {zero_op, neg_op, unsigned_overflow, signed_overflow}, 4'b0110);
        step(0, 0, 1, 0, 0, 2'b00, 0, 0, 16'h2300);
        check("sub_r3", data_out, 16'hFFFE);

        // PC wrap, branch, branch without enable
        step(0, 0, 1, 0, 0, 2'b00, 0, 0, 16'h801F);
        step(1, 1, 0, 0, 0, 2'b00, 0, 0, 16'h0);
        check("pc_31", ram_addr, 5'd31);
        step(0, 1, 0, 0, 0, 2'b00, 0, 0, 16'h0);
        check("pc_wrap", ram_addr, 5'd0);
        step(0, 0, 1, 0, 0, 2'b00, 0, 0, 16'h8014);
        step(1, 1, 0, 0, 0, 2'b00, 0, 0, 16'h0);
        check("pc_branch", ram_addr, 5'h14);
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, 16'h0);
        check("pc_hold", ram_addr, 5'h14);

        // LOAD/STORE and same-cycle write/read of R2
        step(0, 0, 1, 1, 0, 2'b00, 0, 0, 16'h1207);
        check("load_addr", ram_addr, 5'd7);
        step(0, 0, 0, 1, 1, 2'b00, 1, 0, 16'hBEEF);
        step(0, 0, 1, 0, 0, 2'b00, 0, 0, 16'h2207);
        check("store_data", data_out, 16'hBEEF);
        c_sel = 1; write_reg_enable = 1; ir_enable = 0; data_in = 16'h1111;
        #1 check("no_bypass", data_out, 16'hBEEF);
        @(posedge clk); #1;
        check("after_write", data_out, 16'h1111);

        // R0 behaviour
        load_reg(2'd0, 16'h1234);
        step(0, 0, 1, 0, 0, 2'b00, 0, 0, 16'h2000);
`ifdef KS_R0_ZERO_EN
        check("r0_read", data_out, 16'h0000);
`else
        check("r0_read", data_out, 16'h1234);
`endif

        // Mid-cycle reset with a write pending, then first edge honours enables
        load_reg(2'd1, 16'h00F0);
        step(0, 0, 1, 1, 0, 2'b00, 0, 0, 16'h2107);
        c_sel = 1; write_reg_enable = 1; flags_reg_enable = 1; data_in = 16'hDEAD;
        #2 rst = 1'b1;
        #1;
        check("rst_ram_addr", ram_addr, 5'd0);
        check("rst_flags", {zero_op, neg_op, unsigned_overflow, signed_overflow}, 4'b0000);
        check("rst_decode", decoded_instruction, I_NOP);
        check("rst_data_out", data_out, 16'h0);
        @(posedge clk); #1 rst = 1'b0;
        step(0, 0, 1, 0, 0, 2'b00, 0, 0, 16'h1300);
        check("post_rst_ir", decoded_instruction, I_LOAD);

        // Randomized traffic; the per-cycle compare process does the checking
        for (int n = 0; n < 600; n++) begin
            logic [15:0] din;
            din = 16'($urandom);
            if ($urandom_range(0, 3) == 0) din[3:0] = 4'hF;
            rst = ($urandom_range(0, 59) == 0);
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 2'($urandom), 1'($urandom), 1'($urandom), din);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
